// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIV_WIDTH = 4;

    // One spare bit so the counter can hold the final value 2*WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(2 * w) + 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// Single restoring-division cell: shift one dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   pr_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   pr_o,
    output logic             q_o
);

    logic [WIDTH+1:0] ext;

    // The shifted value gets one extra bit so the "trial is non-negative" test
    // stays exact even when divisor==0 lets the remainder fill all its bits.
    assign ext  = {pr_i, bit_i};
    assign q_o  = (ext >= {2'b00, divisor_i});
    assign pr_o = q_o ? (ext[WIDTH:0] - {1'b0, divisor_i}) : ext[WIDTH:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor,
// one quotient bit per clock, valid/ready on both sides, no overlap between ops.
module seq_restoring_divider
    import seq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DW);

    state_e            state_q;
    logic [DW-1:0]     dq_q;
    logic [WIDTH-1:0]  dvs_q;
    logic [WIDTH:0]    pr_q;
    logic [WIDTH:0]    pr_d;
    logic              qbit_d;
    logic [CW-1:0]     cnt_q;
    logic              dbz_r_q;

    logic              in_ready_q;
    logic              out_valid_q;
    logic [DW-1:0]     quotient_q;
    logic [WIDTH-1:0]  remainder_q;
    logic              dbz_q;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .pr_i     (pr_q),
        .bit_i    (dq_q[DW-1]),
        .divisor_i(dvs_q),
        .pr_o     (pr_d),
        .q_o      (qbit_d)
    );

    // Dividend and quotient share one shift register: dividend bits leave at
    // the MSB while quotient bits enter at the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dq_q        <= '0;
            dvs_q       <= '0;
            pr_q        <= '0;
            cnt_q       <= '0;
            dbz_r_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dq_q       <= dividend;
                        dvs_q      <= divisor;
                        pr_q       <= '0;
                        cnt_q      <= '0;
                        dbz_r_q    <= (divisor == '0);
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (cnt_q == LAST) begin
                        quotient_q  <= dq_q;
                        remainder_q <= pr_q[WIDTH-1:0];
                        dbz_q       <= dbz_r_q;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        pr_q  <= pr_d;
                        dq_q  <= {dq_q[DW-2:0], qbit_d};
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
